time_ascii_sender: RTL
======================

// Module: time_ascii_sender
// PURPOSE
//  UART reporting path, the transmit-side counterpart of the command decoder.
//  On a send request it snapshots the current watch/stopwatch time.
//  It formats the snapshot as ASCII "M HH:MM:SS.CC\r\n".
//  It feeds the frame byte by byte to the uart_tx block over a tx_start/tx_done handshake.
//  Sits between the time counters / CU outputs and uart_tx.
// PARAMETERS
//  SEND_CRLF   1   1: append 0x0D 0x0A (15-byte frame); 0: omit them (13-byte frame)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  reset, asynchronous, active-high
//  send      in   1  1-cycle request to transmit one frame
//  mode      in   1  0 = stopwatch (prefix 'S'), 1 = watch (prefix 'W')
//  hour      in   5  hours, 0..23
//  min       in   6  minutes, 0..59
//  sec       in   6  seconds, 0..59
//  msec      in   7  centiseconds, 0..99
//  tx_busy   in   1  uart_tx is shifting a byte
//  tx_done   in   1  1-cycle pulse: uart_tx finished current byte
//  tx_data   out  8  byte presented to uart_tx, valid while tx_start=1
//  tx_start  out  1  1-cycle pulse: launch tx_data
//  busy      out  1  frame in progress (snapshot taken, last byte not done)
//  frame_done out 1  1-cycle pulse after last byte's tx_done
// BEHAVIOUR
//  - Reset: state IDLE; tx_data=8'h00, tx_start=0, busy=0, frame_done=0;
//    byte index=0; snapshot regs=0. Reset mid-frame aborts immediately; no further tx_start.
//  - FSM IDLE -> START -> WAIT -> (START | FIN) -> IDLE.
//  - IDLE: send=1 latches mode,hour,min,sec,msec.
//    busy=1 from next cycle; index=0; go START. send while busy=1 is ignored (no queue).
//  - START: when tx_busy=0, drive tx_data=byte[index] and pulse tx_start for exactly 1 cycle.
//    Go WAIT. If tx_busy=1, hold in START with tx_start=0.
//  - WAIT: on tx_done=1: if index==LAST go FIN, else index+=1 and go START.
//    Next tx_start is never earlier than 1 cycle after tx_done.
//  - FIN: frame_done=1 for 1 cycle, busy=0 same cycle; return IDLE.
//    A send in that same cycle is ignored.
//  - tx_done outside WAIT is ignored.
//  - Frame bytes (index: content):
//    0 'W'/'S', 1 ' ', 2-3 hour tens/ones, 4 ':', 5-6 min, 7 ':', 8-9 sec,
//    10 '.', 11-12 msec, 13 8'h0D, 14 8'h0A.
//    LAST = 14 if SEND_CRLF else 12.
//  - Digits: tens = v/10, ones = v%10, char = 8'h30 + digit.
//    Snapshot fields above 99 saturate to "99"; values <10 send a leading '0'.
//  - Formatting uses the snapshot only; input changes during a frame do not affect bytes sent.
//  - tx_data holds the last launched byte between pulses.
//    Returns to 8'h00 only on reset.
//  - Throughput: one byte per tx_done; per-byte overhead <= 2 clk beyond uart_tx time.
// TESTING
//  1 rst=1 then release -> all outputs 0, state IDLE; no tx_start for 100 cycles.
//  2 mode=1,hour=9,min=5,sec=30,msec=7, send; bench models tx_done 20 cyc after each tx_start
//    -> bytes "W 09:05:30.07\r\n" (15 bytes, last 0D 0A), then 1 frame_done pulse, busy=0.
//  3 mode=0,hour=23,min=59,sec=59,msec=99; change inputs to 0 after send
//    -> "S 23:59:59.99\r\n" unchanged.
//  4 second send pulse mid-frame, and a send in the FIN cycle -> ignored;
//    exactly 15 tx_start pulses total.
//  5 hold tx_busy=1 for 50 cyc before byte 0 -> tx_start waits, then fires once tx_busy=0.
//    Spurious tx_done in IDLE -> no effect.
//  6 rst asserted after byte 6 -> tx_start=0, busy=0 at once.
//    New send after release restarts at byte 0.
//    SEND_CRLF=0 build: 13 bytes, last '7' for msec=7.

Source files
------------

// File: rtl/time_ascii_sender.sv
// Snapshots watch/stopwatch time on send and streams "M HH:MM:SS.CC[\r\n]" to uart_tx.
// One byte per tx_done; tx_start is held off while tx_busy=1; a send while busy is dropped.
module time_ascii_sender #(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic       mode,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] msec,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [3:0] LAST = SEND_CRLF ? 4'd14 : 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FIN} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_idx;
  logic       r_mode;
  logic [4:0] r_hour;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic [6:0] r_msec;
  logic       r_tx_start;
  logic [7:0] r_tx_data;
  logic [7:0] w_byte;
  logic       w_accept;
  logic       w_launch;
  logic       w_advance;

  // Fields above 99 saturate so the two-digit slot never overflows.
  function automatic logic [7:0] digit_char(input logic [6:0] v, input logic ones);
    logic [6:0] s;
    logic [6:0] d;
    s = (v > 7'd99) ? 7'd99 : v;
    d = ones ? (s % 7'd10) : (s / 7'd10);
    return 8'h30 + {1'b0, d};
  endfunction

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = r_mode ? 8'h57 : 8'h53;
      4'd1:    w_byte = 8'h20;
      4'd2:    w_byte = digit_char({2'b00, r_hour}, 1'b0);
      4'd3:    w_byte = digit_char({2'b00, r_hour}, 1'b1);
      4'd4:    w_byte = 8'h3A;
      4'd5:    w_byte = digit_char({1'b0, r_min}, 1'b0);
      4'd6:    w_byte = digit_char({1'b0, r_min}, 1'b1);
      4'd7:    w_byte = 8'h3A;
      4'd8:    w_byte = digit_char({1'b0, r_sec}, 1'b0);
      4'd9:    w_byte = digit_char({1'b0, r_sec}, 1'b1);
      4'd10:   w_byte = 8'h2E;
      4'd11:   w_byte = digit_char(r_msec, 1'b0);
      4'd12:   w_byte = digit_char(r_msec, 1'b1);
      4'd13:   w_byte = 8'h0D;
      4'd14:   w_byte = 8'h0A;
      default: w_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_launch  = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (send) begin
          w_accept = 1'b1;
          w_next   = S_START;
        end
      end
      S_START: begin
        if (!tx_busy) begin
          w_launch = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          if (r_idx == LAST) begin
            w_next = S_FIN;
          end else begin
            w_advance = 1'b1;
            w_next    = S_START;
          end
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      r_mode     <= 1'b0;
      r_hour     <= 5'd0;
      r_min      <= 6'd0;
      r_sec      <= 6'd0;
      r_msec     <= 7'd0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_next;
      r_tx_start <= w_launch;
      if (w_launch) begin
        r_tx_data <= w_byte;
      end
      if (w_accept) begin
        r_idx  <= 4'd0;
        r_mode <= mode;
        r_hour <= hour;
        r_min  <= min;
        r_sec  <= sec;
        r_msec <= msec;
      end else if (w_advance) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign busy       = (r_state == S_START) || (r_state == S_WAIT);
  assign frame_done = (r_state == S_FIN);

endmodule
